multi_magic_scoreboard: RTL and testbench

Parametrised successor to the single-packet scoreboard. It tracks up to NUM_TRACK "magic" packets at once through an in-order FIFO-like DUT. Each pop is checked against the data captured at push time. The block sits beside the DUT in formal/simulation harnesses and drives the property signal checked by the assertion layer.

---
 rtl/multi_magic_scoreboard.sv | 136 +++++++++++++
 tb/tb_multi_magic_scoreboard.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_magic_scoreboard.sv
// Scoreboard that tracks up to NUM_TRACK captured packets through an in-order DUT
// and checks each one against the DUT output when it leaves. Optional macro: SB_STICKY_FAIL_EN.
module multi_magic_scoreboard #(
  parameter int DEPTH     = 8,
  parameter int WIDTH     = 8,
  parameter int NUM_TRACK = 2,
  parameter int CNTWID    = $clog2(DEPTH) + 1,
  parameter int SLOTW     = (NUM_TRACK > 1) ? $clog2(NUM_TRACK) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] data_out,
  output logic             data_out_vld,
  output logic [SLOTW-1:0] exit_slot,
  output logic             prop_signal,
  output logic [SLOTW:0]   captured_cnt,
  output logic             all_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    DONE  = 2'd2
  } slot_state_t;

  localparam logic [SLOTW:0]    MAX_CNT = (SLOTW + 1)'(NUM_TRACK);
  localparam logic [CNTWID-1:0] FULL    = CNTWID'(DEPTH);
  localparam logic [CNTWID-1:0] ONE     = CNTWID'(1);

  slot_state_t       state  [NUM_TRACK];
  logic [CNTWID-1:0] pos    [NUM_TRACK];
  logic [WIDTH-1:0]  stored [NUM_TRACK];
  logic [CNTWID-1:0] occ;
  logic [SLOTW:0]    cnt;

  logic              push_acc;
  logic              pop_acc;
  logic              cap_found;
  logic [SLOTW-1:0]  cap_idx;
  logic              capture;
  logic [CNTWID-1:0] cap_pos;
  logic              exit_hit;
  logic [SLOTW-1:0]  exit_idx;
  logic [WIDTH-1:0]  exit_data;
  logic              match;

  assign push_acc = push && (occ < FULL);
  assign pop_acc  = pop && (occ != '0);
  assign capture  = start && push_acc && cap_found;
  // A simultaneous pop shifts the new packet one place closer to the head.
  assign cap_pos  = pop_acc ? occ : (occ + ONE);

  // Scan downwards so the lowest-index idle slot is the one left selected.
  always_comb begin
    cap_found = 1'b0;
    cap_idx   = '0;
    for (int i = NUM_TRACK - 1; i >= 0; i--) begin
      if (state[i] == IDLE) begin
        cap_found = 1'b1;
        cap_idx   = SLOTW'(i);
      end
    end
  end

  always_comb begin
    exit_hit  = 1'b0;
    exit_idx  = '0;
    exit_data = '0;
    for (int i = 0; i < NUM_TRACK; i++) begin
      if (pop_acc && (state[i] == TRACK) && (pos[i] == ONE)) begin
        exit_hit  = 1'b1;
        exit_idx  = SLOTW'(i);
        exit_data = stored[i];
      end
    end
  end

  assign match = (exit_data == data_out);

  always_comb begin
    all_done = 1'b1;
    for (int i = 0; i < NUM_TRACK; i++) begin
      if (state[i] != DONE) all_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= '0;
      cnt <= '0;
      for (int i = 0; i < NUM_TRACK; i++) begin
        state[i]  <= IDLE;
        pos[i]    <= '0;
        stored[i] <= '0;
      end
    end else begin
      if (push_acc && !pop_acc) occ <= occ + ONE;
      else if (pop_acc && !push_acc) occ <= occ - ONE;

      if (capture && (cnt < MAX_CNT)) cnt <= cnt + 1'b1;

      for (int i = 0; i < NUM_TRACK; i++) begin
        if (capture && (cap_idx == SLOTW'(i))) begin
          state[i]  <= TRACK;
          pos[i]    <= cap_pos;
          stored[i] <= data_in;
        end else if ((state[i] == TRACK) && pop_acc) begin
          pos[i] <= pos[i] - ONE;
          if (pos[i] == ONE) state[i] <= DONE;
        end
      end
    end
  end

`ifdef SB_STICKY_FAIL_EN
  logic fail;

  always_ff @(posedge clk) begin
    if (rst) fail <= 1'b0;
    else if (exit_hit && !match) fail <= 1'b1;
  end

  assign prop_signal = !fail && (!exit_hit || match);
`else
  assign prop_signal = !exit_hit || match;
`endif

  assign data_out_vld = exit_hit;
  assign exit_slot    = exit_idx;
  assign captured_cnt = cnt;

endmodule

// File: tb/tb_multi_magic_scoreboard.sv
// Bench for multi_magic_scoreboard: directed scenarios plus random traffic against a
// packet-queue reference model. Honours SB_STICKY_FAIL_EN when defined.
module tb_multi_magic_scoreboard;

  localparam int DEPTH     = 8;
  localparam int WIDTH     = 8;
  localparam int NUM_TRACK = 2;
  localparam int SLOTW     = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             push;
  logic             pop;
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             data_out_vld;
  logic [SLOTW-1:0] exit_slot;
  logic             prop_signal;
  logic [SLOTW:0]   captured_cnt;
  logic             all_done;

  multi_magic_scoreboard #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH),
    .NUM_TRACK(NUM_TRACK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .start(start),
    .data_in(data_in),
    .data_out(data_out),
    .data_out_vld(data_out_vld),
    .exit_slot(exit_slot),
    .prop_signal(prop_signal),
    .captured_cnt(captured_cnt),
    .all_done(all_done)
  );

  always #5 clk = ~clk;

  // Reference model: the DUT contents as a queue; tag is the slot that owns the packet or -1.
  typedef struct {
    logic [WIDTH-1:0] data;
    int               tag;
  } pkt_t;

  pkt_t q[$];
  int   m_captured;
  int   m_exited;
  bit   m_fail;

  bit   e_vld;
  int   e_slot;
  bit   e_match;
  bit   e_prop;
  bit   e_done;
  int   e_cnt;

  int   n_checks;
  int   n_fail;

  // Drive one cycle's inputs and derive the expected outputs from the model.
  task automatic apply(input bit p, input bit o, input bit s,
                       input logic [WIDTH-1:0] din, input logic [WIDTH-1:0] dout);
    push     = p;
    pop      = o;
    start    = s;
    data_in  = din;
    data_out = dout;
    @(negedge clk);
    e_vld   = o && (q.size() > 0) && (q[0].tag >= 0);
    e_slot  = e_vld ? q[0].tag : 0;
    e_match = (q.size() > 0) ? (q[0].data == dout) : 1'b1;
    e_prop  = !m_fail && (!e_vld || e_match);
    e_done  = (m_exited == NUM_TRACK);
    e_cnt   = m_captured;
  endtask

  // Advance the model across the same edge the DUT sees.
  task automatic commit();
    bit   pa;
    bit   oa;
    pkt_t pk;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_captured = 0;
      m_exited   = 0;
      m_fail     = 1'b0;
    end else begin
      pa = push && (q.size() < DEPTH);
      oa = pop && (q.size() > 0);
`ifdef SB_STICKY_FAIL_EN
      if (e_vld && !e_match) m_fail = 1'b1;
`endif
      if (oa) begin
        if (q[0].tag >= 0) m_exited++;
        void'(q.pop_front());
      end
      if (pa) begin
        pk.data = data_in;
        pk.tag  = -1;
        if (start && (m_captured < NUM_TRACK)) begin
          pk.tag = m_captured;
          m_captured++;
        end
        q.push_back(pk);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply(0, 0, 0, 8'h00, 8'h00);
    commit();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    apply(0, 0, 0, 8'h00, 8'h00);
    commit();
    apply(0, 0, 0, 8'h00, 8'h00);
    commit();
    rst = 1'b0;
    apply(0, 0, 0, 8'h00, 8'h00);
    n_checks++; if (data_out_vld !== 1'b0) begin n_fail++; $display("[TB] FAIL reset vld: got %0b want 0", data_out_vld); end
    n_checks++; if (exit_slot !== '0) begin n_fail++; $display("[TB] FAIL reset exit_slot: got %0d want 0", exit_slot); end
    n_checks++; if (prop_signal !== 1'b1) begin n_fail++; $display("[TB] FAIL reset prop: got %0b want 1", prop_signal); end
    n_checks++; if (all_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset all_done: got %0b want 0", all_done); end
    n_checks++; if (captured_cnt !== '0) begin n_fail++; $display("[TB] FAIL reset cnt: got %0d want 0", captured_cnt); end
    commit();
  endtask

  task automatic test_single_capture();
    do_reset();
    apply(1, 0, 1, 8'hA5, 8'h00);
    commit();
    apply(0, 1, 0, 8'h00, 8'hA5);
    n_checks++; if (data_out_vld !== 1'b1) begin n_fail++; $display("[TB] FAIL single vld: got %0b want 1", data_out_vld); end
    n_checks++; if (exit_slot !== 1'b0) begin n_fail++; $display("[TB] FAIL single slot: got %0d want 0", exit_slot); end
    n_checks++; if (prop_signal !== 1'b1) begin n_fail++; $display("[TB] FAIL single prop: got %0b want 1", prop_signal); end
    n_checks++; if (all_done !== 1'b0) begin n_fail++; $display("[TB] FAIL single all_done: got %0b want 0", all_done); end
    n_checks++; if (captured_cnt !== 2'd1) begin n_fail++; $display("[TB] FAIL single cnt: got %0d want 1", captured_cnt); end
    commit();
  endtask

  task automatic test_overlap();
    do_reset();
    apply(1, 0, 1, 8'h11, 8'h00); commit();
    apply(1, 0, 0, 8'h22, 8'h00); commit();
    apply(1, 0, 1, 8'h33, 8'h00); commit();
    apply(0, 1, 0, 8'h00, 8'h11);
    n_checks++; if (data_out_vld !== 1'b1 || exit_slot !== 1'b0) begin n_fail++; $display("[TB] FAIL overlap pop1: got vld=%0b slot=%0d want vld=1 slot=0", data_out_vld, exit_slot); end
    commit();
    apply(0, 1, 0, 8'h00, 8'h22);
    n_checks++; if (data_out_vld !== 1'b0) begin n_fail++; $display("[TB] FAIL overlap pop2: got vld=%0b want 0", data_out_vld); end
    commit();
    apply(0, 1, 0, 8'h00, 8'h33);
    n_checks++; if (data_out_vld !== 1'b1 || exit_slot !== 1'b1 || prop_signal !== 1'b1) begin n_fail++; $display("[TB] FAIL overlap pop3: got vld=%0b slot=%0d prop=%0b want 1 1 1", data_out_vld, exit_slot, prop_signal); end
    commit();
    apply(0, 0, 0, 8'h00, 8'h00);
    n_checks++; if (all_done !== 1'b1) begin n_fail++; $display("[TB] FAIL overlap all_done: got %0b want 1", all_done); end
    n_checks++; if (captured_cnt !== 2'd2) begin n_fail++; $display("[TB] FAIL overlap cnt: got %0d want 2", captured_cnt); end
    commit();
  endtask

  task automatic test_mismatch();
    bit want_after;
`ifdef SB_STICKY_FAIL_EN
    want_after = 1'b0;
`else
    want_after = 1'b1;
`endif
    do_reset();
    apply(1, 0, 1, 8'h5A, 8'h00); commit();
    apply(0, 1, 0, 8'h00, 8'h5B);
    n_checks++; if (data_out_vld !== 1'b1 || prop_signal !== 1'b0) begin n_fail++; $display("[TB] FAIL mismatch exit: got vld=%0b prop=%0b want vld=1 prop=0", data_out_vld, prop_signal); end
    commit();
    apply(0, 0, 0, 8'h00, 8'h00);
    n_checks++; if (prop_signal !== want_after) begin n_fail++; $display("[TB] FAIL mismatch after: got prop=%0b want %0b", prop_signal, want_after); end
    commit();
    apply(0, 0, 0, 8'h00, 8'h00);
    n_checks++; if (prop_signal !== want_after) begin n_fail++; $display("[TB] FAIL mismatch later: got prop=%0b want %0b", prop_signal, want_after); end
    commit();
  endtask

  task automatic test_full_empty();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      apply(1, 0, 0, 8'(i + 1), 8'h00);
      commit();
    end
    apply(1, 0, 1, 8'hEE, 8'h00); commit();
    apply(0, 0, 0, 8'h00, 8'h00);
    n_checks++; if (captured_cnt !== 2'd0) begin n_fail++; $display("[TB] FAIL full capture: got cnt=%0d want 0", captured_cnt); end
    commit();
    for (int i = 0; i < DEPTH; i++) begin
      apply(0, 1, 0, 8'h00, 8'(i + 1));
      n_checks++; if (data_out_vld !== 1'b0) begin n_fail++; $display("[TB] FAIL drain vld: got %0b want 0", data_out_vld); end
      commit();
    end
    apply(0, 1, 0, 8'h00, 8'hEE);
    n_checks++; if (data_out_vld !== 1'b0) begin n_fail++; $display("[TB] FAIL empty pop vld: got %0b want 0", data_out_vld); end
    commit();
    // Capture while popping an empty DUT: pop is ignored and the packet exits on the next pop.
    apply(1, 1, 1, 8'h3C, 8'h00); commit();
    apply(0, 1, 0, 8'h00, 8'h3C);
    n_checks++; if (data_out_vld !== 1'b1 || exit_slot !== 1'b0 || prop_signal !== 1'b1) begin n_fail++; $display("[TB] FAIL empty capture exit: got vld=%0b slot=%0d prop=%0b want 1 0 1", data_out_vld, exit_slot, prop_signal); end
    commit();
  endtask

  task automatic test_simultaneous();
    do_reset();
    apply(1, 0, 0, 8'h01, 8'h00); commit();
    apply(1, 0, 0, 8'h02, 8'h00); commit();
    apply(1, 0, 0, 8'h03, 8'h00); commit();
    apply(1, 1, 1, 8'h44, 8'h01);
    n_checks++; if (data_out_vld !== 1'b0) begin n_fail++; $display("[TB] FAIL simul pop vld: got %0b want 0", data_out_vld); end
    commit();
    apply(0, 1, 0, 8'h00, 8'h02);
    n_checks++; if (data_out_vld !== 1'b0) begin n_fail++; $display("[TB] FAIL simul pop1 vld: got %0b want 0", data_out_vld); end
    commit();
    apply(0, 1, 0, 8'h00, 8'h03);
    n_checks++; if (data_out_vld !== 1'b0) begin n_fail++; $display("[TB] FAIL simul pop2 vld: got %0b want 0", data_out_vld); end
    commit();
    apply(0, 1, 0, 8'h00, 8'h44);
    n_checks++; if (data_out_vld !== 1'b1 || exit_slot !== 1'b0 || prop_signal !== 1'b1) begin n_fail++; $display("[TB] FAIL simul pop3: got vld=%0b slot=%0d prop=%0b want 1 0 1", data_out_vld, exit_slot, prop_signal); end
    commit();
  endtask

  task automatic test_reset_mid_track();
    do_reset();
    apply(1, 0, 0, 8'h10, 8'h00); commit();
    apply(1, 0, 1, 8'h20, 8'h00); commit();
    rst = 1'b1;
    apply(1, 1, 1, 8'h30, 8'h10); commit();
    rst = 1'b0;
    apply(0, 0, 0, 8'h00, 8'h00);
    n_checks++; if (captured_cnt !== 2'd0 || all_done !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset state: got cnt=%0d done=%0b want 0 0", captured_cnt, all_done); end
    commit();
    for (int i = 0; i < 2; i++) begin
      apply(0, 1, 0, 8'h00, 8'h20);
      n_checks++; if (data_out_vld !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset pop vld: got %0b want 0", data_out_vld); end
      commit();
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    bit               p;
    bit               o;
    bit               s;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst  = ($urandom_range(0, 39) == 0);
      p    = ($urandom_range(0, 99) < 55);
      o    = ($urandom_range(0, 99) < 45);
      s    = ($urandom_range(0, 3) == 0);
      din  = WIDTH'($urandom);
      dout = (q.size() > 0) ? q[0].data : WIDTH'($urandom);
      if ($urandom_range(0, 15) == 0) dout = dout ^ 8'h01;
      apply(p, o, s, din, dout);
      n_checks++; if (data_out_vld !== e_vld) begin n_fail++; $display("[TB] FAIL random vld c=%0d: got %0b want %0b", c, data_out_vld, e_vld); end
      if (e_vld) begin
        n_checks++; if (exit_slot !== SLOTW'(e_slot)) begin n_fail++; $display("[TB] FAIL random slot c=%0d: got %0d want %0d", c, exit_slot, e_slot); end
      end
      n_checks++; if (prop_signal !== e_prop) begin n_fail++; $display("[TB] FAIL random prop c=%0d: got %0b want %0b", c, prop_signal, e_prop); end
      n_checks++; if (all_done !== e_done) begin n_fail++; $display("[TB] FAIL random done c=%0d: got %0b want %0b", c, all_done, e_done); end
      n_checks++; if (captured_cnt !== (SLOTW + 1)'(e_cnt)) begin n_fail++; $display("[TB] FAIL random cnt c=%0d: got %0d want %0d", c, captured_cnt, e_cnt); end
      commit();
    end
    rst = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    m_captured = 0;
    m_exited   = 0;
    m_fail     = 1'b0;
    rst        = 1'b1;
    push       = 1'b0;
    pop        = 1'b0;
    start      = 1'b0;
    data_in    = '0;
    data_out   = '0;
    #1;
    test_reset();
    test_single_capture();
    test_overlap();
    test_mismatch();
    test_full_empty();
    test_simultaneous();
    test_reset_mid_track();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
